// File: rtl/encrypt_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_sequencer_pkg
// Description : Shared types and constants for the encrypt sequencer.
//               - State encoding (IDLE..DONE = 0..7). Each state's number is
//                 also the bit that it lights on state_led.
//               - Bit positions of the strobes inside the packed strobe
//                 vector that the decoder produces.
// Revision    : 1.0 - initial release
// ============================================================================
package encrypt_sequencer_pkg;

    localparam int STATE_W = 3;
    localparam int LED_W   = 8;
    localparam int COUNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_READ  = 3'd3,
        ST_CHECK = 3'd4,
        ST_WRITE = 3'd5,
        ST_INC   = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Positions inside the packed strobe vector
    localparam int STB_CONST_DRIVE   = 0;
    localparam int STB_ELEMENT_WRITE = 1;
    localparam int STB_ELEMENT_DRIVE = 2;
    localparam int STB_I_WRITE       = 3;
    localparam int STB_I_DRIVE       = 4;
    localparam int STB_PLUS1_DRIVE   = 5;
    localparam int STB_ADDRESS_WRITE = 6;
    localparam int STB_MEMORY_WRITE  = 7;
    localparam int STB_MEMORY_DRIVE  = 8;
    localparam int STB_W             = 9;

endpackage
`default_nettype wire

// File: rtl/encrypt_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_sequencer_decode
// Description : Purely combinational decode from the state register to the
//               bus strobes, busy, done and the one-hot state LED.
//               Because it has no input other than the state, all of these
//               outputs depend on the state register only (Moore outputs).
// Ports       : i_state     - current FSM state
//               o_strobes   - packed strobe vector (STB_* bit positions)
//               o_busy      - high in every state except IDLE
//               o_done      - high only in DONE
//               o_state_led - bit n set while in state n
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_sequencer_decode
    import encrypt_sequencer_pkg::*;
(
    input  state_t             i_state,
    output logic [STB_W-1:0]   o_strobes,
    output logic               o_busy,
    output logic               o_done,
    output logic [LED_W-1:0]   o_state_led
);

    localparam logic [LED_W-1:0] c_led_one = LED_W'(1);

    always_comb begin
        o_strobes = '0;
        case (i_state)
            ST_INIT: begin
                o_strobes[STB_CONST_DRIVE] = 1'b1;
                o_strobes[STB_I_WRITE]     = 1'b1;
            end
            ST_ADDR: begin
                o_strobes[STB_I_DRIVE]       = 1'b1;
                o_strobes[STB_ADDRESS_WRITE] = 1'b1;
            end
            ST_READ: begin
                o_strobes[STB_MEMORY_DRIVE]  = 1'b1;
                o_strobes[STB_ELEMENT_WRITE] = 1'b1;
            end
            // The address latch still holds i from ADDR, so WRITE lands on
            // the same location that READ fetched from.
            ST_WRITE: begin
                o_strobes[STB_ELEMENT_DRIVE] = 1'b1;
                o_strobes[STB_MEMORY_WRITE]  = 1'b1;
            end
            ST_INC: begin
                o_strobes[STB_PLUS1_DRIVE] = 1'b1;
                o_strobes[STB_I_WRITE]     = 1'b1;
            end
            default: begin
                // IDLE, CHECK and DONE leave the bus undriven
            end
        endcase

        o_busy      = (i_state != ST_IDLE);
        o_done      = (i_state == ST_DONE);
        o_state_led = c_led_one << i_state;
    end

endmodule
`default_nettype wire

// File: rtl/encrypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : encrypt_sequencer
// Description : Moore FSM that walks the shared 8-bit bus datapath over a RAM
//               buffer. For each element it latches address i, reads the
//               element, tests for the sentinel, writes encrypt(element)
//               back and advances i. A run ends on a sentinel element or
//               after MAX_ELEMS elements. All bus drive enables come from
//               here, so at most one tristate drives the bus in any cycle.
// Parameters  : START_ADDR - first RAM address, driven onto the bus in INIT
//               MAX_ELEMS  - element budget per run (1..255)
// Ports       : clock, reset (async, active-low), start (level, sampled in
//               IDLE), sentinel (sampled in CHECK); strobes const_drive,
//               element_write, element_drive, i_write, i_drive, plus1_drive,
//               address_write, memory_write, memory_drive; busy, done,
//               count (elements encrypted this run), state_led (one-hot
//               state), const_value (the value the const tristate drives).
// Revision    : 1.0 - initial release
// ============================================================================
module encrypt_sequencer
    import encrypt_sequencer_pkg::*;
#(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter int         MAX_ELEMS  = 16
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               sentinel,
    output logic               const_drive,
    output logic               element_write,
    output logic               element_drive,
    output logic               i_write,
    output logic               i_drive,
    output logic               plus1_drive,
    output logic               address_write,
    output logic               memory_write,
    output logic               memory_drive,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic [LED_W-1:0]   state_led,
    output logic [7:0]         const_value
);

    localparam logic [COUNT_W-1:0] c_max_elems = COUNT_W'(MAX_ELEMS);

    state_t             state_q;
    state_t             state_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] count_inc;
    logic [STB_W-1:0]   strobes;

    // ------------------------------------------------------------------
    // State and count registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and count update
    // ------------------------------------------------------------------
    // MAX_ELEMS is at most 255, so this never wraps.
    assign count_inc = count_q + COUNT_W'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_INIT;
            ST_INIT: begin
                state_d = ST_ADDR;
                count_d = '0;
            end
            ST_ADDR:  state_d = ST_READ;
            ST_READ:  state_d = ST_CHECK;
            // The sentinel element is neither written nor counted.
            ST_CHECK: state_d = sentinel ? ST_DONE : ST_WRITE;
            ST_WRITE: state_d = ST_INC;
            ST_INC: begin
                count_d = count_inc;
                state_d = (count_inc == c_max_elems) ? ST_DONE : ST_ADDR;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    encrypt_sequencer_decode u_decode (
        .i_state     (state_q),
        .o_strobes   (strobes),
        .o_busy      (busy),
        .o_done      (done),
        .o_state_led (state_led)
    );

    assign const_drive   = strobes[STB_CONST_DRIVE];
    assign element_write = strobes[STB_ELEMENT_WRITE];
    assign element_drive = strobes[STB_ELEMENT_DRIVE];
    assign i_write       = strobes[STB_I_WRITE];
    assign i_drive       = strobes[STB_I_DRIVE];
    assign plus1_drive   = strobes[STB_PLUS1_DRIVE];
    assign address_write = strobes[STB_ADDRESS_WRITE];
    assign memory_write  = strobes[STB_MEMORY_WRITE];
    assign memory_drive  = strobes[STB_MEMORY_DRIVE];

    assign count       = count_q;
    assign const_value = START_ADDR;

endmodule
`default_nettype wire
